// File: rtl/qam_demod_if.sv
// rtl/qam_demod_if.sv - sample/reference inputs and demodulator outputs of qam_demod
interface qam_demod_if;
    logic               en;
    logic               sym_strobe;
    logic signed [15:0] signal_in;
    logic signed [15:0] sine_in;
    logic signed [15:0] cosine_in;
    logic [1:0]         data_out;
    logic               data_valid;
    logic               serial_out;
    logic               serial_valid;
    logic               short_window;
    logic               sat_flag;
    logic               overrun;

    modport master (
        output en, sym_strobe, signal_in, sine_in, cosine_in,
        input  data_out, data_valid, serial_out, serial_valid, short_window, sat_flag, overrun
    );

    modport slave (
        input  en, sym_strobe, signal_in, sine_in, cosine_in,
        output data_out, data_valid, serial_out, serial_valid, short_window, sat_flag, overrun
    );
endinterface

// File: rtl/qam_demod.sv
// rtl/qam_demod.sv - coherent QPSK integrate-and-dump demodulator with bit re-serialiser
module qam_demod #(
    parameter int ACC_W       = 40,
    parameter int MIN_SAMPLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    qam_demod_if.slave  bus
);
    localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_ZERO = '0;

    typedef enum logic [1:0] {S_IDLE, S_BIT1, S_BIT0} ser_state_t;

    logic signed [31:0]      p_s, p_c;
    logic                    en_d, stb_d;
    logic signed [ACC_W-1:0] acc_s, acc_c;
    logic signed [ACC_W-1:0] ext_s, ext_c;
    logic [ACC_W:0]          add_s, add_c;
    logic [CNT_W-1:0]        cnt;
    logic                    armed;
    ser_state_t              state, state_nxt;
    logic                    emit;
    logic [1:0]              shreg;

    // Signed add clamped to the accumulator range; MSB of the result flags a clamp.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1])
            return {1'b1, (s[ACC_W] ? ACC_MIN : ACC_MAX)};
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    assign ext_s = ACC_W'(p_s);
    assign ext_c = ACC_W'(p_c);
    assign add_s = sat_add(acc_s, ext_s);
    assign add_c = sat_add(acc_c, ext_c);

    // Stage 1: register the two mixer products and delay the strobes to match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_s   <= '0;
            p_c   <= '0;
            en_d  <= 1'b0;
            stb_d <= 1'b0;
        end else begin
            p_s   <= 32'(bus.signal_in) * 32'(bus.sine_in);
            p_c   <= 32'(bus.signal_in) * 32'(bus.cosine_in);
            en_d  <= bus.en;
            stb_d <= bus.sym_strobe;
        end
    end

    // Stage 2: integrate products, dump and slice the old window on each strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_s            <= '0;
            acc_c            <= '0;
            cnt              <= '0;
            armed            <= 1'b0;
            bus.data_out     <= 2'b00;
            bus.data_valid   <= 1'b0;
            bus.short_window <= 1'b0;
            bus.sat_flag     <= 1'b0;
        end else begin
            bus.data_valid   <= 1'b0;
            bus.short_window <= 1'b0;
            if (stb_d) begin
                // The very first strobe only opens a window; nothing meaningful to dump yet.
                if (armed) begin
                    if (cnt >= CNT_W'(MIN_SAMPLES)) begin
                        bus.data_out   <= {acc_s > ACC_ZERO, acc_c > ACC_ZERO};
                        bus.data_valid <= 1'b1;
                    end else begin
                        bus.short_window <= 1'b1;
                    end
                end
                armed <= 1'b1;
                // A sample coinciding with the strobe starts the new window.
                if (en_d) begin
                    acc_s <= ext_s;
                    acc_c <= ext_c;
                    cnt   <= CNT_W'(1);
                end else begin
                    acc_s <= '0;
                    acc_c <= '0;
                    cnt   <= '0;
                end
            end else if (en_d) begin
                acc_s <= add_s[ACC_W-1:0];
                acc_c <= add_c[ACC_W-1:0];
                if (cnt != '1)
                    cnt <= cnt + CNT_W'(1);
                if (add_s[ACC_W] || add_c[ACC_W])
                    bus.sat_flag <= 1'b1;
            end
        end
    end

    // Serialiser state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Serialiser next state: a fresh symbol always wins and restarts at the high bit.
    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        if (bus.data_valid) begin
            state_nxt = S_BIT1;
        end else begin
            case (state)
                S_BIT1: if (bus.en) begin
                    emit      = 1'b1;
                    state_nxt = S_BIT0;
                end
                S_BIT0: if (bus.en) begin
                    emit      = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Serialiser datapath: shift out MSB first, flag symbols that arrive mid-shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg            <= 2'b00;
            bus.serial_out   <= 1'b0;
            bus.serial_valid <= 1'b0;
            bus.overrun      <= 1'b0;
        end else begin
            bus.serial_valid <= emit;
            if (bus.data_valid)
                shreg <= bus.data_out;
            else if (emit)
                shreg <= {shreg[0], 1'b0};
            if (emit)
                bus.serial_out <= shreg[1];
            if (bus.data_valid && state != S_IDLE)
                bus.overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_qam_demod.sv
// tb/tb_qam_demod.sv - randomized and directed bench for qam_demod against a window-level model
module tb_qam_demod;
    localparam int     ACC_W   = 33;
    localparam int     N       = 8192;
    localparam int     NEVER   = 2147483647;
    localparam longint ACC_MAX = (longint'(1) <<< (ACC_W-1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W-1));

    logic clk = 1'b0;
    logic rst = 1'b1;

    qam_demod_if bus();
    qam_demod #(.ACC_W(ACC_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int sin_t[8] = '{0, 5657, 8000, 5657, 0, -5657, -8000, -5657};
    int cos_t[8] = '{8000, 5657, 0, -5657, -8000, -5657, 0, 5657};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // window-level reference model
    longint     m_acc_s, m_acc_c;
    int         m_cnt;
    bit         m_armed;
    bit         exp_dv[N];
    bit         exp_sw[N];
    bit         exp_sv[N];
    bit         exp_so_at[N];
    logic [1:0] exp_do_at[N];
    int         sat_from, ovr_from;
    logic [1:0] exp_data;
    bit         exp_so;
    bit         pend_q[$];

    // observations
    logic [1:0] obs_do_q[$];
    bit         obs_ser[$];
    int         obs_dv_cnt, obs_sw_cnt, obs_dv_cyc, stb_cyc;
    logic [1:0] tx_q[$];
    logic [1:0] eq[$];
    bit         eb[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            exp_dv[i] = 0; exp_sw[i] = 0; exp_sv[i] = 0; exp_so_at[i] = 0; exp_do_at[i] = 2'b00;
        end
        m_acc_s = 0; m_acc_c = 0; m_cnt = 0; m_armed = 0;
        sat_from = NEVER; ovr_from = NEVER;
        exp_data = 2'b00; exp_so = 0;
        pend_q.delete();
    endtask

    task automatic clear_obs();
        obs_do_q.delete(); obs_ser.delete();
        obs_dv_cnt = 0; obs_sw_cnt = 0; obs_dv_cyc = -1;
    endtask

    function automatic longint clip(input longint v, input int n);
        if (v > ACC_MAX || v < ACC_MIN) begin
            if (sat_from > n + 2) sat_from = n + 2;
            return (v > ACC_MAX) ? ACC_MAX : ACC_MIN;
        end
        return v;
    endfunction

    task automatic model_step(input bit en, input bit stb, input int sig, input int s, input int c);
        longint ps, pc;
        ps = longint'(sig) * longint'(s);
        pc = longint'(sig) * longint'(c);
        if (stb) begin
            if (m_armed) begin
                if (m_cnt >= 2) begin
                    exp_dv[cyc+2]    = 1;
                    exp_do_at[cyc+2] = {m_acc_s > 0, m_acc_c > 0};
                end else begin
                    exp_sw[cyc+2] = 1;
                end
            end
            m_armed = 1;
            m_acc_s = en ? ps : 0;
            m_acc_c = en ? pc : 0;
            m_cnt   = en ? 1 : 0;
        end else if (en) begin
            m_acc_s = clip(m_acc_s + ps, cyc);
            m_acc_c = clip(m_acc_c + pc, cyc);
            if (m_cnt < 65535) m_cnt++;
        end
        if (exp_dv[cyc]) begin
            if (pend_q.size() != 0 && ovr_from > cyc + 1) ovr_from = cyc + 1;
            pend_q.delete();
            pend_q.push_back(exp_do_at[cyc][1]);
            pend_q.push_back(exp_do_at[cyc][0]);
        end else if (en && pend_q.size() != 0) begin
            exp_sv[cyc+1]    = 1;
            exp_so_at[cyc+1] = pend_q.pop_front();
        end
    endtask

    task automatic step(input bit en, input bit stb, input int sig, input int s, input int c);
        if (cyc + 3 >= N) begin
            n_fail++;
            $display("FAIL cycle_budget: got %0d expected below %0d", cyc, N - 3);
            $fatal(1, "cycle budget exhausted");
        end
        @(posedge clk);
        #1;
        bus.en = en; bus.sym_strobe = stb;
        bus.signal_in = 16'(sig); bus.sine_in = 16'(s); bus.cosine_in = 16'(c);
        model_step(en, stb, sig, s, c);
        @(negedge clk);
        if (exp_dv[cyc]) exp_data = exp_do_at[cyc];
        if (exp_sv[cyc]) exp_so = exp_so_at[cyc];
        check("data_valid", bus.data_valid, exp_dv[cyc]);
        check("data_out", bus.data_out, exp_data);
        check("short_window", bus.short_window, exp_sw[cyc]);
        check("serial_valid", bus.serial_valid, exp_sv[cyc]);
        check("serial_out", bus.serial_out, exp_so);
        check("sat_flag", bus.sat_flag, cyc >= sat_from);
        check("overrun", bus.overrun, cyc >= ovr_from);
        if (bus.data_valid === 1'b1) begin
            obs_dv_cnt++; obs_do_q.push_back(bus.data_out); obs_dv_cyc = cyc;
        end
        if (bus.short_window === 1'b1) obs_sw_cnt++;
        if (bus.serial_valid === 1'b1) obs_ser.push_back(bus.serial_out);
        cyc++;
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        bus.en = 0; bus.sym_strobe = 0; bus.signal_in = 0; bus.sine_in = 0; bus.cosine_in = 0;
        #1;
        check("rst_data_out", bus.data_out, 0);
        check("rst_data_valid", bus.data_valid, 0);
        check("rst_serial_out", bus.serial_out, 0);
        check("rst_serial_valid", bus.serial_valid, 0);
        check("rst_short_window", bus.short_window, 0);
        check("rst_sat_flag", bus.sat_flag, 0);
        check("rst_overrun", bus.overrun, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic send_symbol(input logic [1:0] sym, input bit idles);
        int sig;
        for (int k = 0; k < 8; k++) begin
            sig = ((sym[1] ? sin_t[k] : -sin_t[k]) + (sym[0] ? cos_t[k] : -cos_t[k])) / 2;
            step(1, k == 0, sig, sin_t[k], cos_t[k]);
            if (idles && $urandom_range(0, 3) == 0)
                step(0, 0, rnd16(), rnd16(), rnd16());
        end
    endtask

    task automatic check_do_seq(input string tag);
        check({tag, "_len"}, obs_do_q.size(), eq.size());
        for (int i = 0; i < eq.size(); i++)
            if (i < obs_do_q.size()) check(tag, obs_do_q[i], eq[i]);
    endtask

    task automatic check_ser_seq(input string tag);
        check({tag, "_len"}, obs_ser.size(), eb.size());
        for (int i = 0; i < eb.size(); i++)
            if (i < obs_ser.size()) check(tag, obs_ser[i], eb[i]);
    endtask

    initial begin
        bus.en = 0; bus.sym_strobe = 0; bus.signal_in = 0; bus.sine_in = 0; bus.cosine_in = 0;
        model_reset();
        clear_obs();
        async_reset();

        // sine-only symbol, first strobe only arms
        clear_obs();
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 16384, 16384, 0);
        stb_cyc = cyc;
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        check("sine_dv_count", obs_dv_cnt, 1);
        check("sine_short_count", obs_sw_cnt, 0);
        check("sine_latency", obs_dv_cyc - stb_cyc, 2);
        eq = {2'd2};
        check_do_seq("sine_data");
        eb = {1'b1, 1'b0};
        check_ser_seq("sine_serial");

        // quadrature symbols over a full reference period
        clear_obs();
        send_symbol(2'b00, 0);
        send_symbol(2'b11, 0);
        send_symbol(2'b01, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        eq = {2'd0, 2'd0, 2'd3, 2'd1};
        check_do_seq("quad_data");
        eb = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        check_ser_seq("quad_serial");

        // strobe sample belongs to the new window only
        clear_obs();
        for (int i = 0; i < 3; i++) step(1, 0, 100, 100, 0);
        step(1, 1, 1000, -1000, 0);
        for (int i = 0; i < 2; i++) step(1, 0, 100, 100, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        eq = {2'd2, 2'd0};
        check_do_seq("boundary_data");

        // one-sample and zero-sample windows
        clear_obs();
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        check("short_dv_count", obs_dv_cnt, 1);
        check("short_sw_count", obs_sw_cnt, 2);

        // random loopback
        async_reset();
        clear_obs();
        tx_q.delete();
        for (int k = 0; k < 200; k++) begin
            logic [1:0] sym;
            sym = 2'($urandom_range(0, 3));
            tx_q.push_back(sym);
            send_symbol(sym, 1);
        end
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0);
        check("loop_bit_count", obs_ser.size(), 2 * tx_q.size());
        for (int k = 0; k < tx_q.size(); k++) begin
            if (2 * k + 1 < obs_ser.size()) begin
                check("loop_bit_hi", obs_ser[2*k], tx_q[k][1]);
                check("loop_bit_lo", obs_ser[2*k+1], tx_q[k][0]);
            end
        end
        check("loop_overrun", bus.overrun, 0);

        // saturation with a 33-bit accumulator
        clear_obs();
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, -32768, -32768, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        eq = {2'd0, 2'd2};
        check_do_seq("sat_data");
        check("sat_set", bus.sat_flag, 1);
        for (int k = 0; k < 3; k++) send_symbol(2'($urandom_range(0, 3)), 1);
        check("sat_sticky", bus.sat_flag, 1);

        // new symbol before the previous one is serialised
        step(1, 1, 1000, 1000, 1000);
        step(1, 0, 1000, 1000, 1000);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 1000, 1000, 1000);
        check("ovr_set", bus.overrun, 1);
        check("ovr_data", bus.data_out, 3);

        // mid-window reset clears everything and disarms
        async_reset();
        clear_obs();
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        check("post_rst_dv", obs_dv_cnt, 0);
        check("post_rst_short", obs_sw_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
